// File: rtl/quad_speed_meter.sv
// Multi-channel quadrature encoder speed meter: synchronises A/B pairs, decodes
// direction, accumulates saturating signed ticks per window and strobes the result.
module quad_speed_meter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int WIN_CYCLES  = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2*NUM_CH-1:0]     enc,
  input  logic                    clear_err,
  output logic [NUM_CH*CNT_W-1:0] speed,
  output logic                    speed_valid,
  output logic [NUM_CH-1:0]       dir,
  output logic [NUM_CH-1:0]       err,
  output logic [NUM_CH-1:0]       ovf
);

  localparam int WIN_W  = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  ACC_MAX   = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0]  ACC_MIN   = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W:0]    ONE       = (CNT_W+1)'(1);

  logic [2*NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [2*NUM_CH-1:0] cur;
  logic [2*NUM_CH-1:0] prev_q;
  logic [FILL_W-1:0]   fill_q;
  logic                primed_q;
  logic [NUM_CH-1:0]   fwd, rev, bad;
  logic [NUM_CH-1:0]   fwd_q, rev_q, bad_q;
  logic [CNT_W-1:0]    acc_q   [NUM_CH];
  logic [CNT_W:0]      sum     [NUM_CH];
  logic [CNT_W-1:0]    acc_sat [NUM_CH];
  logic [NUM_CH-1:0]   clip;
  logic [NUM_CH-1:0]   wovf_q;
  logic [WIN_W-1:0]    win_q;
  logic                terminal;

  assign cur      = sync_q[SYNC_STAGES-1];
  assign terminal = (win_q == WIN_LAST);

  // Forward step: s == {p[0], ~p[1]}; reverse: s == {~p[0], p[1]}; both bits flipped is illegal.
  always_comb begin
    fwd = '0;
    rev = '0;
    bad = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      fwd[ch] = primed_q && (cur[2*ch+1] == prev_q[2*ch]) && (cur[2*ch] != prev_q[2*ch+1]);
      rev[ch] = primed_q && (cur[2*ch+1] != prev_q[2*ch]) && (cur[2*ch] == prev_q[2*ch+1]);
      bad[ch] = primed_q && (cur[2*ch+1] != prev_q[2*ch+1]) && (cur[2*ch] != prev_q[2*ch]);
    end
  end

  always_comb begin
    clip = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      sum[ch] = {acc_q[ch][CNT_W-1], acc_q[ch]};
      if (fwd_q[ch])
        sum[ch] = sum[ch] + ONE;
      else if (rev_q[ch])
        sum[ch] = sum[ch] - ONE;
      clip[ch]    = sum[ch][CNT_W] != sum[ch][CNT_W-1];
      acc_sat[ch] = clip[ch] ? (sum[ch][CNT_W] ? ACC_MIN : ACC_MAX) : sum[ch][CNT_W-1:0];
    end
  end

  // Priming waits until the synchroniser has flushed its reset zeros, so a pin
  // held at 11 through reset never shows up as a false 00->11 transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= '0;
      prev_q      <= '0;
      fill_q      <= '0;
      primed_q    <= 1'b0;
      fwd_q       <= '0;
      rev_q       <= '0;
      bad_q       <= '0;
      wovf_q      <= '0;
      win_q       <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
      dir         <= '0;
      err         <= '0;
      ovf         <= '0;
    end else begin
      sync_q[0] <= enc;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= cur;
      if (!primed_q) begin
        fill_q <= fill_q + FILL_W'(1);
        if (fill_q == FILL_LAST) primed_q <= 1'b1;
      end
      fwd_q       <= fwd;
      rev_q       <= rev;
      bad_q       <= bad;
      win_q       <= terminal ? '0 : win_q + WIN_W'(1);
      speed_valid <= terminal;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (fwd_q[ch] || rev_q[ch]) dir[ch] <= fwd_q[ch];
        if (bad_q[ch])
          err[ch] <= 1'b1;
        else if (clear_err)
          err[ch] <= 1'b0;
        if (terminal) begin
          speed[ch*CNT_W +: CNT_W] <= acc_sat[ch];
          ovf[ch]                  <= wovf_q[ch] | clip[ch];
          acc_q[ch]                <= '0;
          wovf_q[ch]               <= 1'b0;
        end else begin
          acc_q[ch]  <= acc_sat[ch];
          wovf_q[ch] <= wovf_q[ch] | clip[ch];
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_speed_meter.sv
// Randomised scoreboard bench for quad_speed_meter: two instances (16-bit and
// 4-bit speed words) checked against a step-list reference model.
module tb_quad_speed_meter;

  localparam int NCH = 4;
  localparam int W   = 512;
  localparam int SS  = 2;
  localparam int LAT = SS + 2;  // enc written at a negedge -> lands in acc this many edges later

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              clear_err = 1'b0;
  logic [2*NCH-1:0]  enc = '0;
  logic [NCH*16-1:0] speed16;
  logic [NCH*4-1:0]  speed4;
  logic              sv16, sv4;
  logic [NCH-1:0]    dir16, dir4, err16, err4, ovf16, ovf4;

  always #5 clk = ~clk;

  quad_speed_meter #(.NUM_CH(NCH), .CNT_W(16), .WIN_CYCLES(W), .SYNC_STAGES(SS)) dut16 (
    .clk(clk), .reset(reset), .enc(enc), .clear_err(clear_err), .speed(speed16),
    .speed_valid(sv16), .dir(dir16), .err(err16), .ovf(ovf16));

  quad_speed_meter #(.NUM_CH(NCH), .CNT_W(4), .WIN_CYCLES(W), .SYNC_STAGES(SS)) dut4 (
    .clk(clk), .reset(reset), .enc(enc), .clear_err(clear_err), .speed(speed4),
    .speed_valid(sv4), .dir(dir4), .err(err4), .ovf(ovf4));

  typedef struct { int land; int ch; int d; bit bad; } ev_t;
  typedef struct packed {
    logic [NCH*16-1:0] sp16;
    logic [NCH*4-1:0]  sp4;
    logic [NCH-1:0]    ov16;
    logic [NCH-1:0]    ov4;
  } win_t;

  ev_t  pend[$];
  win_t expq[$];

  int checks = 0;
  int errors = 0;
  int m_edge = 0;
  int acc16[NCH], acc4[NCH], mdv[NCH];
  bit wo16[NCH], wo4[NCH], mbad[NCH];
  logic [NCH-1:0] m_dir = '0, m_err = '0;
  logic m_sv = 1'b0;
  logic [1:0] gseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic int gpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int sat_step(input int a, input int d, input int w, output bit c);
    int hi = (1 << (w - 1)) - 1;
    int lo = -(1 << (w - 1));
    int r  = a + d;
    c = 1'b0;
    if (r > hi) begin r = hi; c = 1'b1; end
    if (r < lo) begin r = lo; c = 1'b1; end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Position distance in the forward Gray cycle: 1 = +1, 3 = -1, 2 = illegal.
  task automatic set_ch(input int ch, input logic [1:0] v);
    ev_t e;
    int diff = (gpos(v) - gpos(enc[2*ch +: 2]) + 4) % 4;
    e.land = m_edge + LAT;
    e.ch   = ch;
    e.d    = (diff == 1) ? 1 : (diff == 3) ? -1 : 0;
    e.bad  = (diff == 2);
    if (diff != 0) pend.push_back(e);
    enc[2*ch +: 2] = v;
  endtask

  task automatic fwd_step(input int ch);
    set_ch(ch, gseq[(gpos(enc[2*ch +: 2]) + 1) % 4]);
  endtask

  task automatic rev_step(input int ch);
    set_ch(ch, gseq[(gpos(enc[2*ch +: 2]) + 3) % 4]);
  endtask

  task automatic wait_off(input int off);
    tick();
    for (int i = 0; i < W && (m_edge % W) != off; i++) tick();
  endtask

  // Reference model: applies each step on the edge it lands, closes windows every W edges.
  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_edge = 0;
      pend.delete();
      expq.delete();
      m_dir = '0;
      m_err = '0;
      m_sv  = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        acc16[ch] = 0; acc4[ch] = 0; wo16[ch] = 1'b0; wo4[ch] = 1'b0;
      end
    end else begin
      bit c16, c4;
      ev_t e;
      win_t wr;
      m_edge++;
      for (int ch = 0; ch < NCH; ch++) begin mdv[ch] = 0; mbad[ch] = 1'b0; end
      while (pend.size() > 0 && pend[0].land <= m_edge) begin
        e = pend.pop_front();
        if (e.bad) mbad[e.ch] = 1'b1;
        else mdv[e.ch] = e.d;
      end
      for (int ch = 0; ch < NCH; ch++) begin
        if (mdv[ch] != 0) m_dir[ch] = (mdv[ch] > 0);
        if (mbad[ch]) m_err[ch] = 1'b1;
        else if (clear_err) m_err[ch] = 1'b0;
        acc16[ch] = sat_step(acc16[ch], mdv[ch], 16, c16);
        acc4[ch]  = sat_step(acc4[ch], mdv[ch], 4, c4);
        wo16[ch]  = wo16[ch] | c16;
        wo4[ch]   = wo4[ch] | c4;
      end
      m_sv = (m_edge % W == 0);
      if (m_sv) begin
        for (int ch = 0; ch < NCH; ch++) begin
          wr.sp16[ch*16 +: 16] = acc16[ch][15:0];
          wr.sp4[ch*4 +: 4]    = acc4[ch][3:0];
          wr.ov16[ch]          = wo16[ch];
          wr.ov4[ch]           = wo4[ch];
          acc16[ch] = 0; acc4[ch] = 0; wo16[ch] = 1'b0; wo4[ch] = 1'b0;
        end
        expq.push_back(wr);
      end
    end
  end

  // Monitor: per-cycle status checks, window results popped on each strobe.
  initial forever begin
    win_t wr;
    @(posedge clk);
    #1;
    if (reset) begin
      chk("valid16", 64'(sv16), 64'(m_sv));
      chk("valid4", 64'(sv4), 64'(m_sv));
      chk("dir16", 64'(dir16), 64'(m_dir));
      chk("dir4", 64'(dir4), 64'(m_dir));
      chk("err16", 64'(err16), 64'(m_err));
      chk("err4", 64'(err4), 64'(m_err));
      if (sv16 || sv4) begin
        if (expq.size() == 0) begin
          chk("strobe_unexpected", 64'(1), 64'(0));
        end else begin
          wr = expq.pop_front();
          chk("speed16", speed16, 64'(wr.sp16));
          chk("speed4", 64'(speed4), 64'(wr.sp4));
          chk("ovf16", 64'(ovf16), 64'(wr.ov16));
          chk("ovf4", 64'(ovf4), 64'(wr.ov4));
        end
      end
    end
  end

  initial begin
    int r;
    repeat (3) tick();
    chk("rst_speed16", speed16, '0);
    chk("rst_speed4", 64'(speed4), '0);
    chk("rst_valid", 64'({sv16, sv4}), '0);
    chk("rst_dir", 64'({dir16, dir4}), '0);
    chk("rst_err", 64'({err16, err4}), '0);
    chk("rst_ovf", 64'({ovf16, ovf4}), '0);
    reset = 1'b1;
    repeat (5) tick();

    // Forward then reverse on ch0, 100 steps each, states held 2 cycles; then an idle window.
    wait_off(4);
    for (int i = 0; i < 100; i++) begin fwd_step(0); tick(); tick(); end
    wait_off(4);
    for (int i = 0; i < 100; i++) begin rev_step(0); tick(); tick(); end
    wait_off(4);

    // Illegal jump on ch2, clear, then a clear pulse landing with a new illegal jump.
    set_ch(2, 2'b11);
    repeat (7) tick();
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    repeat (3) tick();
    set_ch(2, 2'b00);
    repeat (3) tick();
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    repeat (5) tick();

    // Saturation on ch1: 20 steps then 3 steps in the following window.
    wait_off(4);
    for (int i = 0; i < 20; i++) begin fwd_step(1); tick(); tick(); end
    wait_off(4);
    for (int i = 0; i < 3; i++) begin fwd_step(1); tick(); tick(); end

    // Steps on ch3 landing two edges before, exactly on, and one edge after the terminal edge.
    wait_off(W - 6);
    fwd_step(3); tick(); tick();
    fwd_step(3); tick();
    fwd_step(3); tick();

    // Random traffic over two windows on all channels.
    for (int c = 0; c < 2 * W; c++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        r = $urandom_range(0, 15);
        if (r < 4) fwd_step(ch);
        else if (r < 7) rev_step(ch);
        else if (r == 7) set_ch(ch, ~enc[2*ch +: 2]);
      end
      clear_err = ($urandom_range(0, 31) == 0);
      tick();
    end
    clear_err = 1'b0;

    // Reset mid-window with ch0 parked at 11; only post-release steps may count.
    wait_off(4);
    for (int i = 0; i < 30; i++) begin fwd_step(0); tick(); tick(); end
    while (enc[1:0] != 2'b11) begin fwd_step(0); tick(); tick(); end
    reset = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 7; i++) begin fwd_step(0); tick(); tick(); end
    wait_off(4);
    wait_off(4);

    chk("queue_empty", 64'(expq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
